trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Trap controller: takes synchronous exceptions, drains the pipe before entering
// machine interrupts, handles mret, and owns mstatus.MIE/MPIE and the mip register.
module trap_ctrl #(
    parameter int ISA_C = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        exc_id_valid_i,
    input  logic        exc_ex_valid_i,
    input  logic [4:0]  exc_id_cause_i,
    input  logic [4:0]  exc_ex_cause_i,
    input  logic [31:0] pc_id_i,
    input  logic [31:0] pc_ex_i,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        csr_mstatus_we_i,
    input  logic [31:0] csr_mstatus_wdata_i,
    input  logic        mret_i,
    input  logic        pipe_drained_i,
    output logic        mstatus_mie_o,
    output logic        mstatus_mpie_o,
    output logic [31:0] mip_o,
    output logic        save_pc_id_o,
    output logic        save_pc_ex_o,
    output logic        cause_intr_o,
    output logic [4:0]  cause_code_o,
    output logic        pc_set_o,
    output logic [31:0] pc_target_o,
    output logic        flush_o,
    output logic        halt_o
);

    typedef enum logic [1:0] {IDLE, DRAIN, TRAP} state_t;

    // Vectored targets are always word aligned; with C enabled only halfword alignment is enforced.
    localparam logic [31:0] ALIGN_MASK = (ISA_C != 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

    state_t      state, state_nxt;
    logic        mie_q, mpie_q;
    logic [31:0] mip_p1;
    logic [31:0] irq_en;
    logic        ipe;
    logic [4:0]  irq_code;
    logic [31:0] base;
    logic [31:0] vec_target;
    logic        trap_entry;
    logic        mret_take;
    logic        unused_inputs;

    function automatic logic [4:0] irq_select(input logic [31:0] pend);
        if (pend[11])      return 5'd11;
        else if (pend[3])  return 5'd3;
        else if (pend[7])  return 5'd7;
        else               return 5'd0;
    endfunction

    assign irq_en     = mip_p1 & mie_i;
    assign ipe        = mie_q & (|irq_en);
    assign irq_code   = irq_select(irq_en);
    assign base       = {mtvec_i[31:2], 2'b00};
    assign vec_target = (base + {25'b0, irq_code, 2'b00}) & ALIGN_MASK;

    assign unused_inputs = ^{pc_id_i, pc_ex_i, csr_mstatus_wdata_i[31:8],
                             csr_mstatus_wdata_i[6:4], csr_mstatus_wdata_i[2:0]};

    // Stage p1: registered interrupt pending bits
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mip_p1 <= '0;
        end else begin
            mip_p1 <= {20'b0, irq_external_i, 3'b0, irq_timer_i, 3'b0, irq_software_i, 3'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Trap entry and mret take precedence over a software mstatus write in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else if (trap_entry) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (mret_take) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (csr_mstatus_we_i) begin
            mie_q  <= csr_mstatus_wdata_i[3];
            mpie_q <= csr_mstatus_wdata_i[7];
        end
    end

    always_comb begin
        state_nxt    = state;
        save_pc_id_o = 1'b0;
        save_pc_ex_o = 1'b0;
        cause_intr_o = 1'b0;
        cause_code_o = 5'd0;
        pc_set_o     = 1'b0;
        flush_o      = 1'b0;
        pc_target_o  = 32'd0;
        halt_o       = 1'b0;
        trap_entry   = 1'b0;
        mret_take    = 1'b0;
        case (state)
            IDLE: begin
                if (exc_ex_valid_i) begin
                    save_pc_ex_o = 1'b1;
                    cause_code_o = exc_ex_cause_i;
                    pc_set_o     = 1'b1;
                    flush_o      = 1'b1;
                    pc_target_o  = base;
                    trap_entry   = 1'b1;
                end else if (exc_id_valid_i) begin
                    save_pc_id_o = 1'b1;
                    cause_code_o = exc_id_cause_i;
                    pc_set_o     = 1'b1;
                    flush_o      = 1'b1;
                    pc_target_o  = base;
                    trap_entry   = 1'b1;
                end else if (mret_i) begin
                    pc_set_o    = 1'b1;
                    flush_o     = 1'b1;
                    pc_target_o = mepc_i;
                    mret_take   = 1'b1;
                end else if (ipe) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                halt_o = 1'b1;
                if (exc_ex_valid_i) begin
                    save_pc_ex_o = 1'b1;
                    cause_code_o = exc_ex_cause_i;
                    pc_set_o     = 1'b1;
                    flush_o      = 1'b1;
                    pc_target_o  = base;
                    trap_entry   = 1'b1;
                    state_nxt    = IDLE;
                end else if (!ipe) begin
                    state_nxt = IDLE;
                end else if (pipe_drained_i) begin
                    state_nxt = TRAP;
                end
            end
            TRAP: begin
                // The ID instruction never issued, so it is the one that resumes after the handler.
                halt_o       = 1'b1;
                save_pc_id_o = 1'b1;
                cause_intr_o = 1'b1;
                cause_code_o = irq_code;
                pc_set_o     = 1'b1;
                flush_o      = 1'b1;
                pc_target_o  = (mtvec_i[1:0] == 2'b01) ? vec_target : base;
                trap_entry   = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mstatus_mie_o  = mie_q;
    assign mstatus_mpie_o = mpie_q;
    assign mip_o          = mip_p1;

endmodule
